// File: rtl/pwm_bank_pkg.sv
// Shared constants for the PWM bank: register offsets, CTRL bit layout and
// default geometry.
package pwm_bank_pkg;

  localparam int         DEF_CNT_WIDTH = 8;
  localparam logic [9:0] DEF_BASE_ADDR = 10'h3F0;

  localparam logic [3:0] OFF_DUTY0    = 4'd0;
  localparam logic [3:0] OFF_CTRL     = 4'd8;
  localparam logic [3:0] OFF_PRESCALE = 4'd9;
  localparam logic [3:0] OFF_TOP      = 4'd10;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MASK_LSB = 8;
  localparam int CTRL_MASK_MSB = 15;

endpackage

// File: rtl/pwm_channel.sv
// One PWM lane: shadow duty register, period-aligned active copy, and the
// registered compare output.
module pwm_channel
  import pwm_bank_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_duty_we,
  input  logic [CNT_WIDTH-1:0] i_duty_wdata,
  input  logic                 i_en,
  input  logic                 i_mask,
  input  logic                 i_wrap,
  input  logic [CNT_WIDTH-1:0] i_cnt,
  output logic [CNT_WIDTH-1:0] o_duty,
  output logic                 o_pwm
);

  logic [CNT_WIDTH-1:0] r_duty;
  logic [CNT_WIDTH-1:0] r_active;
  logic                 r_pwm;

  // r_active samples the pre-write shadow, so a store landing on a wrap
  // edge only takes effect from the following wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_duty   <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_duty_we) begin
        r_duty <= i_duty_wdata;
      end
      if (!i_en || i_wrap) begin
        r_active <= r_duty;
      end
      r_pwm <= i_en & i_mask & (i_cnt < r_active);
    end
  end

  assign o_duty = r_duty;
  assign o_pwm  = r_pwm;

endmodule

// File: rtl/pwm_bank.sv
// Memory-mapped multi-channel PWM generator: bus decode, control registers,
// shared prescaler/period counter and read-back mux.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int                    CHANNELS   = 8,
  parameter int                    CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEF_BASE_ADDR)
) (
  input  logic                  clk_io,
  input  logic                  reset_io,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [15:0]           wdata_i,
  output logic [15:0]           rdata_o,
  output logic                  sel_o,
  output logic [CHANNELS-1:0]   pwm_o,
  output logic                  period_tick_o
);

  logic [ADDR_WIDTH-1:0] w_diff;
  logic                  w_sel;
  logic                  w_we;
  logic [3:0]            w_off;
  logic                  w_tick;
  logic                  w_wrap;
  logic [15:0]           w_rdata;
  logic [CHANNELS-1:0]   w_duty_we;
  logic [CNT_WIDTH-1:0]  w_duty [CHANNELS];

  logic                  r_en;
  logic [7:0]            r_mask;
  logic [15:0]           r_prescale;
  logic [CNT_WIDTH-1:0]  r_top;
  logic [15:0]           r_pre;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_period_tick;

  // Lower-bound check plus zero upper offset bits avoids overflow of BASE+15.
  assign w_diff = addr_i - BASE_ADDR;
  assign w_sel  = (addr_i >= BASE_ADDR) && (w_diff[ADDR_WIDTH-1:4] == '0);
  assign w_off  = w_diff[3:0];
  assign w_we   = wr_en_i & w_sel;

  always_ff @(posedge clk_io or posedge reset_io) begin
    if (reset_io) begin
      r_en       <= 1'b0;
      r_mask     <= '0;
      r_prescale <= '0;
      r_top      <= '1;
    end else if (w_we) begin
      case (w_off)
        OFF_CTRL: begin
          r_en   <= wdata_i[CTRL_EN_BIT];
          r_mask <= wdata_i[CTRL_MASK_MSB:CTRL_MASK_LSB];
        end
        OFF_PRESCALE: r_prescale <= wdata_i;
        OFF_TOP:      r_top      <= wdata_i[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Magnitude compares make a shrunken PRESCALE/TOP take effect at once.
  assign w_tick = r_en && (r_pre >= r_prescale);
  assign w_wrap = w_tick && (r_cnt >= r_top);

  always_ff @(posedge clk_io or posedge reset_io) begin
    if (reset_io) begin
      r_pre         <= '0;
      r_cnt         <= '0;
      r_period_tick <= 1'b0;
    end else begin
      r_period_tick <= w_wrap;
      if (!r_en) begin
        r_pre <= '0;
        r_cnt <= '0;
      end else if (w_tick) begin
        r_pre <= '0;
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign w_duty_we[gi] = w_we && (w_off == 4'(int'(OFF_DUTY0) + gi));

      pwm_channel #(
        .CNT_WIDTH(CNT_WIDTH)
      ) u_channel (
        .i_clk       (clk_io),
        .i_rst       (reset_io),
        .i_duty_we   (w_duty_we[gi]),
        .i_duty_wdata(wdata_i[CNT_WIDTH-1:0]),
        .i_en        (r_en),
        .i_mask      (r_mask[gi]),
        .i_wrap      (w_wrap),
        .i_cnt       (r_cnt),
        .o_duty      (w_duty[gi]),
        .o_pwm       (pwm_o[gi])
      );
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_off)
        OFF_CTRL:     w_rdata = {r_mask, 7'b0, r_en};
        OFF_PRESCALE: w_rdata = r_prescale;
        OFF_TOP:      w_rdata = 16'(r_top);
        default: begin
          for (int n = 0; n < CHANNELS; n++) begin
            if (w_off == 4'(int'(OFF_DUTY0) + n)) begin
              w_rdata = 16'(w_duty[n]);
            end
          end
        end
      endcase
    end
  end

  assign rdata_o       = w_rdata;
  assign sel_o         = w_sel;
  assign period_tick_o = r_period_tick;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: reset/decode vector table, hand-written
// period-alignment sequences and a randomized run against a cycle model.
module tb_pwm_bank;

  localparam logic [9:0] BASE = 10'h3F0;

  logic        clk_io   = 1'b0;
  logic        reset_io = 1'b1;
  logic        wr_en_i  = 1'b0;
  logic [9:0]  addr_i   = '0;
  logic [15:0] wdata_i  = '0;
  logic [15:0] rdata_o;
  logic        sel_o;
  logic [7:0]  pwm_o;
  logic        period_tick_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_io = ~clk_io;

  pwm_bank #(
    .CHANNELS  (8),
    .CNT_WIDTH (8),
    .ADDR_WIDTH(10),
    .BASE_ADDR (10'h3F0)
  ) dut (
    .clk_io       (clk_io),
    .reset_io     (reset_io),
    .wr_en_i      (wr_en_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rdata_o      (rdata_o),
    .sel_o        (sel_o),
    .pwm_o        (pwm_o),
    .period_tick_o(period_tick_o)
  );

  // Reference model state, in plain integers.
  int         m_duty [8];
  int         m_active [8];
  int         m_ctrl, m_prescale, m_top, m_pre, m_cnt;
  logic [7:0] m_pwm;
  logic       m_ptick;

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic        exp_sel;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];
  int   g1 [5] = '{0, 0, 1, 1, 1};
  int   g2 [8] = '{1, 1, 1, 0, 1, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_sel(input logic [9:0] a);
    return (int'(a) >= 'h3F0) && (int'(a) <= 'h3FF);
  endfunction

  function automatic logic [15:0] model_rdata(input logic [9:0] a);
    int off;
    if (!model_sel(a)) return 16'h0;
    off = int'(a) - 'h3F0;
    if (off < 8)   return 16'(m_duty[off]);
    if (off == 8)  return 16'(m_ctrl);
    if (off == 9)  return 16'(m_prescale);
    if (off == 10) return 16'(m_top);
    return 16'h0;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 8; n++) begin
      m_duty[n]   = 0;
      m_active[n] = 0;
    end
    m_ctrl = 0; m_prescale = 0; m_top = 255; m_pre = 0; m_cnt = 0;
    m_pwm = '0; m_ptick = 1'b0;
  endtask

  task automatic model_step();
    bit en, tick, wrap;
    int mask, off;
    en   = (m_ctrl & 1) != 0;
    mask = (m_ctrl >> 8) & 'hFF;
    tick = en && (m_pre >= m_prescale);
    wrap = tick && (m_cnt >= m_top);
    for (int n = 0; n < 8; n++) begin
      m_pwm[n] = en && (((mask >> n) & 1) != 0) && (m_cnt < m_active[n]);
      if (!en || wrap) m_active[n] = m_duty[n];
    end
    m_ptick = wrap;
    if (!en) begin
      m_pre = 0; m_cnt = 0;
    end else if (tick) begin
      m_pre = 0;
      m_cnt = wrap ? 0 : m_cnt + 1;
    end else begin
      m_pre = m_pre + 1;
    end
    if (wr_en_i && model_sel(addr_i)) begin
      off = int'(addr_i) - 'h3F0;
      if (off < 8)       m_duty[off] = int'(wdata_i) & 'hFF;
      else if (off == 8) m_ctrl      = int'(wdata_i) & 'hFF01;
      else if (off == 9) m_prescale  = int'(wdata_i);
      else if (off == 10) m_top      = int'(wdata_i) & 'hFF;
    end
  endtask

  task automatic cycle();
    @(posedge clk_io);
    if (reset_io) model_reset();
    else model_step();
    @(negedge clk_io);
    chk("model_pwm", pwm_o, m_pwm);
    chk("model_tick", period_tick_o, m_ptick);
    chk("model_sel", sel_o, model_sel(addr_i));
    chk("model_rdata", rdata_o, model_rdata(addr_i));
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [15:0] d);
    wr_en_i = 1'b1; addr_i = a; wdata_i = d;
    cycle();
    wr_en_i = 1'b0;
  endtask

  task automatic check_reset_reads(input string tag);
    for (int o = 0; o <= 10; o++) begin
      addr_i = BASE + 10'(o);
      #1;
      chk(tag, rdata_o, (o == 10) ? 32'h00FF : 32'h0);
    end
  endtask

  initial begin
    int guard;
    int cyc;

    vecs[0]  = '{1'b1, 10'h3EF, 16'hFFFF, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 10'h3FB, 16'hFFFF, 1'b1, 16'h0000};
    vecs[2]  = '{1'b0, 10'h3F0, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{1'b0, 10'h3F8, 16'h0000, 1'b1, 16'h0000};
    vecs[4]  = '{1'b0, 10'h3F9, 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{1'b0, 10'h3FA, 16'h0000, 1'b1, 16'h00FF};
    vecs[6]  = '{1'b1, 10'h3F3, 16'hABCD, 1'b1, 16'h00CD};
    vecs[7]  = '{1'b1, 10'h3FA, 16'h1234, 1'b1, 16'h0034};
    vecs[8]  = '{1'b1, 10'h3F9, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[9]  = '{1'b1, 10'h3F8, 16'hFF00, 1'b1, 16'hFF00};
    vecs[10] = '{1'b0, 10'h3FF, 16'h0000, 1'b1, 16'h0000};
    vecs[11] = '{1'b0, 10'h000, 16'h0000, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 10'h3F3, 16'h0000, 1'b1, 16'h00CD};
    vecs[13] = '{1'b1, 10'h3EF, 16'h0055, 1'b0, 16'h0000};

    model_reset();

    // Power-on reset state.
    repeat (2) @(negedge clk_io);
    chk("rst_pwm", pwm_o, 0);
    chk("rst_tick", period_tick_o, 0);
    check_reset_reads("rst_read");
    @(negedge clk_io);
    reset_io = 1'b0;
    addr_i   = '0;
    cycle();

    // Basic duty 2/4 on channel 0.
    bus_write(BASE + 10'd10, 16'd3);
    bus_write(BASE + 10'd0,  16'd2);
    bus_write(BASE + 10'd8,  16'h0101);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("basic_pwm0", pwm_o[0], (((k - 1) % 4) < 2));
      chk("basic_tick", period_tick_o, (k % 4) == 0);
      chk("basic_pwm_hi", pwm_o[7:1], 0);
    end
    $display("basic duty sequence done");

    // Mid-period duty change: current period stays 2/4, next is 3/4.
    cycle();
    bus_write(BASE + 10'd0, 16'd3);
    chk("glitch_mid_write", pwm_o[0], 1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("glitch_mid", pwm_o[0], g1[k]);
    end
    // Duty write on the wrap edge: applies one period later.
    bus_write(BASE + 10'd0, 16'd1);
    chk("glitch_wrap_write_tick", period_tick_o, 1);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("glitch_wrap", pwm_o[0], g2[k]);
    end
    $display("glitch-free update sequence done");

    // Duty extremes on channels 1 and 2.
    bus_write(BASE + 10'd1, 16'd0);
    bus_write(BASE + 10'd2, 16'd4);
    bus_write(BASE + 10'd8, 16'h0601);
    repeat (8) cycle();
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("ext_pwm1", pwm_o[1], 0);
      chk("ext_pwm2", pwm_o[2], 1);
      chk("ext_pwm0_masked", pwm_o[0], 0);
    end
    $display("extremes sequence done");

    // Asynchronous reset mid-period while enabled.
    chk("pre_reset_pwm2", pwm_o[2], 1);
    #2 reset_io = 1'b1;
    #1;
    chk("async_rst_pwm", pwm_o, 0);
    chk("async_rst_tick", period_tick_o, 0);
    model_reset();
    check_reset_reads("async_rst_read");
    @(negedge clk_io);
    reset_io = 1'b0;
    addr_i   = '0;
    cycle();

    // Decode and read-back vector table.
    for (int i = 0; i < 14; i++) begin
      wr_en_i = vecs[i].wr; addr_i = vecs[i].addr; wdata_i = vecs[i].wdata;
      cycle();
      wr_en_i = 1'b0;
      chk("vec_sel", sel_o, vecs[i].exp_sel);
      chk("vec_rdata", rdata_o, vecs[i].exp_rdata);
      $display("vec %0d wr=%0d addr=%h wdata=%h sel=%0d rdata=%h", i, vecs[i].wr,
               vecs[i].addr, vecs[i].wdata, sel_o, rdata_o);
    end

    // Prescale with TOP shrink while the counter is far beyond it.
    bus_write(BASE + 10'd9,  16'd2);
    bus_write(BASE + 10'd10, 16'd255);
    bus_write(BASE + 10'd8,  16'h0101);
    guard = 0;
    while (m_cnt != 100 && guard < 2000) begin
      cycle();
      guard++;
    end
    chk("shrink_reach_100", (guard < 2000), 1);
    bus_write(BASE + 10'd10, 16'd3);
    cyc = 0;
    do begin
      cycle();
      cyc++;
    end while (!period_tick_o && cyc < 20);
    chk("shrink_wrap_latency_ok", (cyc <= 3), 1);
    cyc = 0;
    do begin
      cycle();
      cyc++;
    end while (!period_tick_o && cyc < 40);
    chk("shrink_period", cyc, 12);
    cyc = 0;
    do begin
      cycle();
      cyc++;
    end while (!period_tick_o && cyc < 40);
    chk("shrink_period2", cyc, 12);
    $display("prescale/top shrink sequence done");

    // Randomized bus traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r, off;
      logic [15:0] d;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        off = $urandom_range(0, 15);
        case (off)
          8:  d = {8'($urandom), 7'b0, ($urandom_range(0, 9) != 0)};
          9:  d = 16'($urandom_range(0, 3));
          10: d = ($urandom_range(0, 7) == 0) ? 16'h00FF : 16'($urandom_range(0, 7));
          default: d = 16'($urandom);
        endcase
        wr_en_i = 1'b1;
        addr_i  = ($urandom_range(0, 19) == 0) ? 10'($urandom) : BASE + 10'(off);
        wdata_i = d;
      end else begin
        wr_en_i = 1'b0;
        addr_i  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : BASE + 10'($urandom_range(0, 15));
        wdata_i = 16'($urandom);
      end
      cycle();
    end
    wr_en_i = 1'b0;
    $display("random traffic done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
